// File: rtl/mem_arbiter_rr.sv
// N-requester main-memory arbiter: priority class + round-robin + aging, with a load tag table.
// Define MEM_ARB_STATS_EN to add the grant_count / stray_resp_count statistics ports.
module mem_arbiter_rr #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 32,
    parameter int BLOCK_W      = 64,
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_store,
    input  logic [NUM_REQ-1:0]         req_prior,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_accepted,
    output logic [ADDR_W-1:0]          proc2mem_addr,
    output logic [BLOCK_W-1:0]         proc2mem_data,
    output logic [1:0]                 proc2mem_command,
    input  logic [TAG_W-1:0]           mem2proc_transaction_tag,
    input  logic [BLOCK_W-1:0]         mem2proc_data,
    input  logic [TAG_W-1:0]           mem2proc_data_tag,
    output logic [NUM_REQ-1:0]         resp_valid,
    output logic [BLOCK_W-1:0]         resp_data,
    output logic [TAG_W-1:0]           resp_tag
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]      grant_count,
    output logic [31:0]                stray_resp_count
`endif
);

    localparam int PTR_W    = $clog2(NUM_REQ);
    localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam int NUM_TAGS = 1 << TAG_W;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_wait [NUM_REQ];
    logic [NUM_TAGS-1:0] r_pending;
    logic [PTR_W-1:0]   r_owner [NUM_TAGS];

    logic [NUM_REQ-1:0] w_starved;
    logic [NUM_REQ-1:0] w_elig_hi;
    logic [NUM_REQ-1:0] w_elig;
    logic [PTR_W-1:0]   w_win;
    logic               w_found;
    logic               w_active;
    logic               w_accept;
    logic               w_hit;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_starved[i] = (r_wait[i] == CNT_W'(STARVE_LIMIT));
        end
    end

    // High class (priority or starved) shadows the low class entirely.
    assign w_elig_hi = req_valid & (req_prior | w_starved);
    assign w_elig    = (|w_elig_hi) ? w_elig_hi : req_valid;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_elig[ptr_add(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = ptr_add(r_rr_ptr, k);
            end
        end
    end

    assign w_active = w_found && !reset;
    assign w_accept = w_active && (mem2proc_transaction_tag != '0);
    assign w_hit    = !reset && (mem2proc_data_tag != '0) && r_pending[mem2proc_data_tag];

    always_comb begin
        req_accepted     = '0;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_command = 2'd0;
        if (w_active) begin
            proc2mem_addr    = req_addr[w_win*ADDR_W +: ADDR_W];
            proc2mem_data    = req_data[w_win*BLOCK_W +: BLOCK_W];
            proc2mem_command = req_store[w_win] ? 2'd2 : 2'd1;
        end
        if (w_accept) req_accepted[w_win] = 1'b1;
    end

    always_comb begin
        resp_valid = '0;
        resp_data  = reset ? '0 : mem2proc_data;
        resp_tag   = reset ? '0 : mem2proc_data_tag;
        if (w_hit) resp_valid[r_owner[mem2proc_data_tag]] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr  <= '0;
            r_pending <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
            for (int t = 0; t < NUM_TAGS; t++) r_owner[t] <= '0;
        end else begin
            if (w_accept) r_rr_ptr <= ptr_add(w_win, 1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_accepted[i]) begin
                    if (!w_starved[i]) r_wait[i] <= r_wait[i] + 1'b1;
                end else begin
                    r_wait[i] <= '0;
                end
            end
            // Clear precedes set so a tag retired and reissued on one edge stays pending.
            if (w_hit) r_pending[mem2proc_data_tag] <= 1'b0;
            if (w_accept && !req_store[w_win]) begin
                r_pending[mem2proc_transaction_tag] <= 1'b1;
                r_owner[mem2proc_transaction_tag]   <= w_win;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_grant_cnt [NUM_REQ];
    logic [31:0] r_stray_cnt;
    logic        w_stray;

    assign w_stray = !reset && (mem2proc_data_tag != '0) && !r_pending[mem2proc_data_tag];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stray_cnt <= '0;
            for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
        end else begin
            if (w_stray) r_stray_cnt <= r_stray_cnt + 32'd1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_accepted[i]) r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gcnt
        assign grant_count[gi*32 +: 32] = r_grant_cnt[gi];
    end
    assign stray_resp_count = r_stray_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr: behavioural model compared every cycle, directed and random stimulus.
module tb_mem_arbiter_rr;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int BW = 64;
    localparam int TW = 4;
    localparam int SL = 4;
    localparam int NT = 16;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req_valid, req_store, req_prior;
    logic [N*AW-1:0] req_addr;
    logic [N*BW-1:0] req_data;
    logic [N-1:0]    req_accepted;
    logic [AW-1:0]   proc2mem_addr;
    logic [BW-1:0]   proc2mem_data;
    logic [1:0]      proc2mem_command;
    logic [TW-1:0]   mem2proc_transaction_tag;
    logic [BW-1:0]   mem2proc_data;
    logic [TW-1:0]   mem2proc_data_tag;
    logic [N-1:0]    resp_valid;
    logic [BW-1:0]   resp_data;
    logic [TW-1:0]   resp_tag;

    mem_arbiter_rr #(
        .NUM_REQ(N), .ADDR_W(AW), .BLOCK_W(BW), .TAG_W(TW), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_prior(req_prior),
        .req_addr(req_addr), .req_data(req_data),
        .req_accepted(req_accepted),
        .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .proc2mem_command(proc2mem_command),
        .mem2proc_transaction_tag(mem2proc_transaction_tag),
        .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: round-robin pointer, per-requester lost-cycle count, owner per tag (-1 = free).
    int m_ptr;
    int m_wait [N];
    int m_owner [NT];
    int m_win;
    int m_acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic at_neg();
        logic [N-1:0]  hi, sel, e_acc, e_rv;
        logic [1:0]    e_cmd;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_data, e_rdata;
        logic [TW-1:0] e_rtag;
        int win;
        @(negedge clock);
        e_acc = '0; e_rv = '0; e_cmd = 2'd0; e_addr = '0; e_data = '0;
        e_rdata = '0; e_rtag = '0; win = -1;
        if (!reset) begin
            for (int i = 0; i < N; i++) hi[i] = req_valid[i] && (req_prior[i] || m_wait[i] == SL);
            sel = (hi != '0) ? hi : req_valid;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && sel[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            if (win >= 0) begin
                e_cmd  = req_store[win] ? 2'd2 : 2'd1;
                e_addr = req_addr[win*AW +: AW];
                e_data = req_data[win*BW +: BW];
                if (mem2proc_transaction_tag != 0) e_acc[win] = 1'b1;
            end
            if (mem2proc_data_tag != 0 && m_owner[mem2proc_data_tag] >= 0)
                e_rv[m_owner[mem2proc_data_tag]] = 1'b1;
            e_rdata = mem2proc_data;
            e_rtag  = mem2proc_data_tag;
        end
        m_win = win;
        chk("model_accepted", 64'(req_accepted), 64'(e_acc));
        chk("model_command", 64'(proc2mem_command), 64'(e_cmd));
        chk("model_addr", 64'(proc2mem_addr), 64'(e_addr));
        chk("model_data", proc2mem_data, e_data);
        chk("model_resp_valid", 64'(resp_valid), 64'(e_rv));
        chk("model_resp_data", resp_data, e_rdata);
        chk("model_resp_tag", 64'(resp_tag), 64'(e_rtag));
    endtask

    task automatic at_pos();
        bit acc;
        @(posedge clock);
        if (reset) begin
            m_ptr = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            for (int t = 0; t < NT; t++) m_owner[t] = -1;
            m_acc = 0;
        end else begin
            acc = (m_win >= 0) && (mem2proc_transaction_tag != 0);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !(acc && m_win == i)) m_wait[i] = (m_wait[i] < SL) ? m_wait[i] + 1 : SL;
                else m_wait[i] = 0;
            end
            if (acc) m_ptr = (m_win + 1) % N;
            if (mem2proc_data_tag != 0 && m_owner[mem2proc_data_tag] >= 0) m_owner[mem2proc_data_tag] = -1;
            if (acc && !req_store[m_win]) m_owner[mem2proc_transaction_tag] = m_win;
            m_acc = acc ? 1 : 0;
        end
        #1;
    endtask

    task automatic step();
        at_neg();
        at_pos();
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_store = '0; req_prior = '0;
        mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        reset = 1'b0;
    endtask

    task automatic new_req(input int i);
        req_valid[i] = 1'b1;
        req_store[i] = ($urandom % 4 == 0);
        req_prior[i] = ($urandom % 4 == 0);
        req_addr[i*AW +: AW] = $urandom;
        req_data[i*BW +: BW] = {$urandom, $urandom};
    endtask

    int s2_exp [6] = '{1, 1, 1, 1, 2, 1};

    initial begin
        int pick, st, t;
        reset = 1'b1;
        idle_inputs();
        req_addr = '0; req_data = '0;
        m_win = -1;
        step();
        at_neg();
        chk("reset_accepted", 64'(req_accepted), 64'd0);
        chk("reset_command", 64'(proc2mem_command), 64'd0);
        at_pos();
        reset = 1'b0;

        // Equal class: strict alternation from pointer 0.
        req_valid = 2'b11; req_addr = {32'h0000_2222, 32'h0000_1111};
        req_data = {64'hBBBB, 64'hAAAA}; mem2proc_transaction_tag = 4'd3;
        for (int c = 0; c < 4; c++) begin
            at_neg();
            chk("rr_alternate", 64'(req_accepted), (c % 2 == 0) ? 64'd1 : 64'd2);
            at_pos();
        end

        // Priority requester vs low requester with aging.
        do_reset();
        req_valid = 2'b11; req_prior = 2'b01; req_store = 2'b11; mem2proc_transaction_tag = 4'd3;
        for (int c = 0; c < 6; c++) begin
            at_neg();
            chk("starve_promote", 64'(req_accepted), 64'(s2_exp[c]));
            at_pos();
        end

        // Load response routed to owner, second hit on retired tag ignored.
        do_reset();
        req_valid = 2'b10; req_addr[AW +: AW] = 32'h0000_1000; mem2proc_transaction_tag = 4'd5;
        at_neg();
        chk("load_accepted", 64'(req_accepted), 64'd2);
        chk("load_addr", 64'(proc2mem_addr), 64'h1000);
        chk("load_command", 64'(proc2mem_command), 64'd1);
        at_pos();
        idle_inputs();
        for (int c = 0; c < 6; c++) step();
        mem2proc_data_tag = 4'd5; mem2proc_data = 64'hDEAD;
        at_neg();
        chk("resp_route", 64'(resp_valid), 64'd2);
        chk("resp_data", resp_data, 64'hDEAD);
        at_pos();
        at_neg();
        chk("resp_repeat", 64'(resp_valid), 64'd0);
        at_pos();

        // Store allocates no tag.
        idle_inputs();
        req_valid = 2'b01; req_store = 2'b01; mem2proc_transaction_tag = 4'd6;
        at_neg();
        chk("store_command", 64'(proc2mem_command), 64'd2);
        chk("store_accepted", 64'(req_accepted), 64'd1);
        at_pos();
        idle_inputs();
        mem2proc_data_tag = 4'd6;
        at_neg();
        chk("store_no_resp", 64'(resp_valid), 64'd0);
        at_pos();

        // Memory rejection leaves pointer in place.
        do_reset();
        req_valid = 2'b11; mem2proc_transaction_tag = 4'd0;
        for (int c = 0; c < 2; c++) begin
            at_neg();
            chk("reject_accepted", 64'(req_accepted), 64'd0);
            chk("reject_command", 64'(proc2mem_command), 64'd1);
            at_pos();
        end
        mem2proc_transaction_tag = 4'd2;
        at_neg();
        chk("retry_accepted", 64'(req_accepted), 64'd1);
        at_pos();

        // Reset drops outstanding tags and silences outputs.
        do_reset();
        req_valid = 2'b01; mem2proc_transaction_tag = 4'd4;
        step();
        reset = 1'b1; req_valid = 2'b11; mem2proc_data_tag = 4'd4; mem2proc_data = 64'h1234;
        at_neg();
        chk("rst_accepted", 64'(req_accepted), 64'd0);
        chk("rst_command", 64'(proc2mem_command), 64'd0);
        chk("rst_addr", 64'(proc2mem_addr), 64'd0);
        chk("rst_data", proc2mem_data, 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        chk("rst_resp_tag", 64'(resp_tag), 64'd0);
        at_pos();
        reset = 1'b0;
        idle_inputs();
        mem2proc_data_tag = 4'd4;
        at_neg();
        chk("post_rst_resp", 64'(resp_valid), 64'd0);
        at_pos();

        // Random traffic obeying hold-until-accepted.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (m_acc != 0 && m_win == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom % 3 != 0)) new_req(i);
            end
            mem2proc_transaction_tag = ($urandom % 4 == 0) ? 4'd0 : TW'(1 + $urandom % 15);
            mem2proc_data = {$urandom, $urandom};
            pick = int'($urandom % 4);
            if (pick == 0) mem2proc_data_tag = 4'd0;
            else if (pick == 1) mem2proc_data_tag = TW'($urandom % 16);
            else begin
                mem2proc_data_tag = 4'd0;
                st = int'($urandom % 16);
                for (int k = 0; k < NT; k++) begin
                    t = (st + k) % NT;
                    if (mem2proc_data_tag == 0 && t != 0 && m_owner[t] >= 0) mem2proc_data_tag = TW'(t);
                end
            end
            reset = ($urandom % 500 == 0);
            step();
            if (reset) begin
                reset = 1'b0;
                req_valid = '0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
